led_pattern_sequencer: RTL

Parametrised, clocked successor to the combinational LED decoders. It latches a pattern word produced by an upstream game-state decoder and drives the LED bank. The pattern can be shown static, blinking, rotating, or progressively filled, stepped by an internal prescaler. It sits between the state/decoder logic and the board LED pins, and its output polarity is selectable.

---
 rtl/led_pkg.sv | 10 +
 rtl/led_tick_prescaler.sv | 23 ++
 rtl/led_pattern_sequencer.sv | 62 ++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings and defaults for the LED pattern sequencer
package led_pkg;
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;
  localparam int NUM_LEDS_DEFAULT = 17;
endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: free-running divider emitting one step pulse every TICK_DIV enabled cycles
module led_tick_prescaler #(
  parameter int TICK_DIV = 50000,
  localparam int CNT_W = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic step
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_wrap;
  assign w_wrap = r_div_cnt == LAST;
  // step is masked by reset and by a restart so it never collides with either
  assign step = en & ~rst & ~clear & w_wrap;
  // divider counts only while enabled and restarts from zero on clear
  always_ff @(posedge clk) begin
    if (rst || clear) r_div_cnt <= '0;
    else if (en) r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
  end
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: latches an LED pattern and animates it as static, blink, rotate or fill
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS   = NUM_LEDS_DEFAULT,
  parameter int TICK_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [NUM_LEDS-1:0] pattern,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                step,
  output logic [1:0]          cur_mode
);
  localparam int FILL_W = $clog2(NUM_LEDS + 1);
  logic [NUM_LEDS-1:0] r_pat, r_disp, w_disp_step, w_mask;
  mode_t               r_mode;
  logic [FILL_W-1:0]   r_fill_cnt, w_fill_nxt;
  logic                r_blink_on, w_blink_nxt;
  led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(load),
    .step (step)
  );
  assign led_out  = ACTIVE_LOW ? ~r_disp : r_disp;
  assign cur_mode = r_mode;
  // next display frame for the latched mode, applied only on a step
  always_comb begin
    w_fill_nxt  = (r_fill_cnt == FILL_W'(NUM_LEDS)) ? '0 : r_fill_cnt + 1'b1;
    w_mask      = ~({NUM_LEDS{1'b1}} << w_fill_nxt);
    w_blink_nxt = ~r_blink_on;
    w_disp_step = r_mode == MODE_BLINK  ? (w_blink_nxt ? r_pat : '0) :
                  r_mode == MODE_ROTATE ? {r_disp[NUM_LEDS-2:0], r_disp[NUM_LEDS-1]} :
                  r_mode == MODE_FILL   ? r_pat & w_mask : r_pat;
  end
  // load restarts the animation and outranks a step; otherwise advance on each step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat      <= '0;
      r_mode     <= MODE_STATIC;
      r_disp     <= '0;
      r_fill_cnt <= '0;
      r_blink_on <= 1'b1;
    end else if (load) begin
      r_pat      <= pattern;
      r_mode     <= mode_t'(mode);
      r_disp     <= (mode == MODE_FILL) ? '0 : pattern;
      r_fill_cnt <= '0;
      r_blink_on <= 1'b1;
    end else if (step) begin
      r_disp     <= w_disp_step;
      r_fill_cnt <= (r_mode == MODE_FILL) ? w_fill_nxt : r_fill_cnt;
      r_blink_on <= (r_mode == MODE_BLINK) ? w_blink_nxt : r_blink_on;
    end
  end
endmodule
